// File: rtl/seg7_scan_reader.sv
// Four-digit multiplexed seven-segment driver that fetches each digit's pattern from a
// lookup table in data memory over a req/gnt port. Optional pattern cache: SEG_CACHE_EN.
module seg7_scan_reader #(
  parameter int          SCAN_DIV   = 50000,
  parameter logic [31:0] TABLE_BASE = 32'h80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_en,
  input  logic [15:0] disp_value,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  input  logic        cache_flush,
  output logic        mem_req,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        busy
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHOW} state_e;

  state_e           state_q, state_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             busy_q, busy_d;

  logic       launch;
  logic       go_idle;
  logic       show;
  logic [7:0] show_pat;
  logic [1:0] next_idx;
  logic [3:0] next_nib;

`ifdef SEG_CACHE_EN
  logic [3:0]  nib_q, nib_d;
  logic        hit_q, hit_d;
  logic [15:0] valid_q, valid_d;
  logic [7:0]  cache_q [16];
  logic        fill_en;
`else
  logic unused_flush;
  assign unused_flush = cache_flush;
`endif

  // Only the low byte of a table word carries the pattern.
  logic unused_rdata;
  assign unused_rdata = &{1'b0, mem_rdata[31:8]};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    digit_idx_d = digit_idx_q;
    scan_cnt_d  = scan_cnt_q;
    an_d        = an_q;
    seg_d       = seg_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    busy_d      = busy_q;
    launch      = 1'b0;
    go_idle     = 1'b0;
    show        = 1'b0;
    show_pat    = mem_rdata[7:0];
    next_idx    = digit_idx_q + 2'd1;
    next_nib    = disp_value[{next_idx, 2'b00} +: 4];
`ifdef SEG_CACHE_EN
    nib_d       = nib_q;
    hit_d       = hit_q;
    fill_en     = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (disp_en) launch = 1'b1;
        else         go_idle = 1'b1;
      end
      S_FETCH: begin
        // Disable outranks a same-cycle grant so a pending fetch is always aborted.
        if (!disp_en) begin
          go_idle = 1'b1;
`ifdef SEG_CACHE_EN
        end else if (hit_q) begin
          show     = 1'b1;
          show_pat = cache_q[nib_q];
`endif
        end else if (mem_gnt) begin
          show = 1'b1;
`ifdef SEG_CACHE_EN
          fill_en = 1'b1;
`endif
        end
      end
      S_SHOW: begin
        if (!disp_en)                                   go_idle = 1'b1;
        else if (scan_cnt_q == CNT_W'(SCAN_DIV - 1))    launch = 1'b1;
        else                                            scan_cnt_d = scan_cnt_q + CNT_W'(1);
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d   = S_IDLE;
      an_d      = 4'hF;
      seg_d     = 8'h00;
      mem_req_d = 1'b0;
      busy_d    = 1'b0;
    end

    // Nibble is snapshotted here; later disp_value changes wait for the next fetch.
    if (launch) begin
      state_d     = S_FETCH;
      digit_idx_d = next_idx;
      scan_cnt_d  = '0;
      an_d        = 4'hF;
      busy_d      = 1'b1;
      mem_addr_d  = TABLE_BASE + 32'({next_nib, 2'b00});
`ifdef SEG_CACHE_EN
      nib_d       = next_nib;
      hit_d       = valid_q[next_nib];
      mem_req_d   = !valid_q[next_nib];
`else
      mem_req_d   = 1'b1;
`endif
    end

    if (show) begin
      state_d    = S_SHOW;
      scan_cnt_d = '0;
      an_d       = ~(4'b0001 << digit_idx_q);
      seg_d      = show_pat;
      mem_req_d  = 1'b0;
      busy_d     = 1'b0;
    end

`ifdef SEG_CACHE_EN
    // Flush wins over a fill landing in the same cycle.
    valid_d = valid_q;
    if (fill_en)     valid_d = valid_q | (16'd1 << nib_q);
    if (cache_flush) valid_d = '0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      digit_idx_q <= 2'd3;
      scan_cnt_q  <= '0;
      an_q        <= 4'hF;
      seg_q       <= 8'h00;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= TABLE_BASE;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_idx_q <= digit_idx_d;
      scan_cnt_q  <= scan_cnt_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SEG_CACHE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nib_q   <= 4'd0;
      hit_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      nib_q   <= nib_d;
      hit_q   <= hit_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: pattern storage has no reset; valid_q alone decides whether an entry is used.
  always_ff @(posedge clk) begin
    if (fill_en) cache_q[nib_q] <= mem_rdata[7:0];
  end
`endif

  assign mem_req  = mem_req_q;
  assign mem_read = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (SCAN_DIV=4): table-driven scan plus hand-written
// sequences for grant stalls, snapshotting, disable abort, async reset and the cache.
module tb_seg7_scan_reader;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_en;
  logic [15:0] disp_value;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        cache_flush;
  logic        mem_req;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_reader #(.SCAN_DIV(SCAN_DIV), .TABLE_BASE(32'h80)) dut (
    .clk(clk), .reset(reset), .disp_en(disp_en), .disp_value(disp_value),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .cache_flush(cache_flush),
    .mem_req(mem_req), .mem_read(mem_read), .mem_addr(mem_addr),
    .an(an), .seg(seg), .busy(busy)
  );

  always #5 clk = ~clk;

  // Data memory: segment table at 0x80, junk in the upper bytes.
  logic [7:0] pat [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  always_comb begin
    mem_rdata = 32'hDEADBEEF;
    if (mem_addr >= 32'h80 && mem_addr < 32'hC0)
      mem_rdata = {24'hA5C3E7, pat[mem_addr[5:2]]};
  end

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        req;
    logic [31:0] addr;
    logic        busy;
    logic        chk_seg;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] e_an, input logic [7:0] e_seg,
                            input logic e_req, input logic [31:0] e_addr, input logic e_busy,
                            input logic chk_seg);
    check({name, ".an"},   32'(an), 32'(e_an));
    if (chk_seg) check({name, ".seg"}, 32'(seg), 32'(e_seg));
    check({name, ".req"},  32'(mem_req), 32'(e_req));
    check({name, ".read"}, 32'(mem_read), 32'(e_req));
    check({name, ".addr"}, mem_addr, e_addr);
    check({name, ".busy"}, 32'(busy), 32'(e_busy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Scan of 16'h3210: per digit one FETCH cycle then four lit cycles; ends on wrap fetch.
    for (int d = 0; d < 4; d++) begin
      vecs[d*5] = '{an: 4'hF, seg: 8'h00, req: 1'b1, addr: 32'h80 + 32'(4*d), busy: 1'b1, chk_seg: 1'b0};
      for (int c = 1; c <= 4; c++)
        vecs[d*5+c] = '{an: ~(4'b0001 << d), seg: pat[d], req: 1'b0,
                        addr: 32'h80 + 32'(4*d), busy: 1'b0, chk_seg: 1'b1};
    end
    vecs[20] = '{an: 4'hF, seg: 8'h00, req: 1'b1, addr: 32'h80, busy: 1'b1, chk_seg: 1'b0};

    reset = 1'b1; disp_en = 1'b0; disp_value = 16'h0000; mem_gnt = 1'b0; cache_flush = 1'b0;
    #12;
    check_outs("reset", 4'hF, 8'h00, 1'b0, 32'h80, 1'b0, 1'b1);
    reset = 1'b0;
    step();
    check_outs("idle", 4'hF, 8'h00, 1'b0, 32'h80, 1'b0, 1'b1);

    // 1: full scan with grant tied high
    disp_en = 1'b1; disp_value = 16'h3210; mem_gnt = 1'b1;
    for (int i = 0; i < 21; i++) begin
      step();
      check_outs($sformatf("scan[%0d]", i), vecs[i].an, vecs[i].seg, vecs[i].req,
                 vecs[i].addr, vecs[i].busy, vecs[i].chk_seg);
    end

    // 2: grant withheld for 10 cycles in FETCH
    mem_gnt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_outs($sformatf("stall[%0d]", i), 4'hF, 8'h00, 1'b1, 32'h80, 1'b1, 1'b0);
    end
    mem_gnt = 1'b1;
    step();
    check_outs("stall_release", 4'hE, 8'h3F, 1'b0, 32'h80, 1'b0, 1'b1);

    // 3: disp_value change while a digit is lit
    disp_value = 16'h0000;
    for (int i = 0; i < 3; i++) step();
    check_outs("d0_end", 4'hE, 8'h3F, 1'b0, 32'h80, 1'b0, 1'b1);
    step();
    check_outs("d1_fetch", 4'hF, 8'h00, 1'b1, 32'h80, 1'b1, 1'b0);
    step();
    check_outs("d1_show", 4'hD, 8'h3F, 1'b0, 32'h80, 1'b0, 1'b1);
    disp_value = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs($sformatf("d1_hold[%0d]", i), 4'hD, 8'h3F, 1'b0, 32'h80, 1'b0, 1'b1);
    end
    step();
    check_outs("d2_fetch", 4'hF, 8'h00, 1'b1, 32'hBC, 1'b1, 1'b0);
    step();
    check_outs("d2_show", 4'hB, 8'h71, 1'b0, 32'hBC, 1'b0, 1'b1);

    // 4: disable in FETCH with a same-cycle grant, then resume at the next digit
    for (int i = 0; i < 4; i++) step();
    check_outs("d3_fetch", 4'hF, 8'h00, 1'b1, 32'hBC, 1'b1, 1'b0);
    disp_en = 1'b0;
    step();
    check_outs("abort", 4'hF, 8'h00, 1'b0, 32'hBC, 1'b0, 1'b1);
    step();
    check_outs("abort_idle", 4'hF, 8'h00, 1'b0, 32'hBC, 1'b0, 1'b1);
    disp_value = 16'h3210; disp_en = 1'b1;
    step();
    check_outs("resume_fetch", 4'hF, 8'h00, 1'b1, 32'h80, 1'b1, 1'b0);
    step();
    check_outs("resume_show", 4'hE, 8'h3F, 1'b0, 32'h80, 1'b0, 1'b1);

    // 5: asynchronous reset mid-SHOW and mid-FETCH, checked between clock edges
    step();
    #2 reset = 1'b1;
    #1 check_outs("areset_show", 4'hF, 8'h00, 1'b0, 32'h80, 1'b0, 1'b1);
    reset = 1'b0;
    mem_gnt = 1'b0;
    step();
    check_outs("post_reset_fetch", 4'hF, 8'h00, 1'b1, 32'h80, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 check_outs("areset_fetch", 4'hF, 8'h00, 1'b0, 32'h80, 1'b0, 1'b1);
    reset = 1'b0;

`ifdef SEG_CACHE_EN
    // 6: cache fill, hits on later scans, flush, and flush beating a same-cycle fill
    begin
      int n_req;
      int n_blank;
      disp_value = 16'h1111; mem_gnt = 1'b1;
      step();
      check_outs("c_miss", 4'hF, 8'h00, 1'b1, 32'h84, 1'b1, 1'b0);
      step();
      check_outs("c_show0", 4'hE, 8'h06, 1'b0, 32'h84, 1'b0, 1'b1);
      n_req = 0; n_blank = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (mem_req) n_req++;
        if (an == 4'hF) n_blank++;
        if (an != 4'hF) check($sformatf("c_seg[%0d]", i), 32'(seg), 32'h06);
      end
      check("c_req_count", 32'(n_req), 32'd0);
      check("c_blank_count", 32'(n_blank), 32'd8);
      cache_flush = 1'b1;
      step();
      cache_flush = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check_outs("c_flush_miss", 4'hF, 8'h00, 1'b1, 32'h84, 1'b1, 1'b0);
      cache_flush = 1'b1;
      step();
      cache_flush = 1'b0;
      check("c_fill_seg", 32'(seg), 32'h06);
      for (int i = 0; i < 4; i++) step();
      check_outs("c_flush_over_fill", 4'hF, 8'h00, 1'b1, 32'h84, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step();
      check_outs("c_hit_again", 4'hF, 8'h00, 1'b0, 32'h84, 1'b1, 1'b0);
      step();
      check("c_hit_an", 32'(an), 32'h7);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
